instr_fetch_seq: RTL and testbench

//  Instruction fetch sequencer that drives the control unit's instruction input.

---
 rtl/instr_fetch_seq.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//
// Instruction fetch sequencer. It owns the program counter, fetches one 16-bit
// instruction at a time from instruction memory over a req/valid handshake, and
// presents each instruction to the control unit's decoder. The decoder's branch,
// self-instruction and end-of-program outputs choose the next instruction.
// There is no prefetch: a new fetch starts only once the presented instruction
// has been committed.
//
// Parameters
//   ADDR_W    width of the PC and of the instruction memory address
//             (must be at least 12 so the branch offset fits)
//   RESET_PC  address of the first instruction fetched after reset
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active high
//   imem_req_o       fetch request, held until imem_valid_i
//   imem_addr_o      fetch address, stable while imem_req_o is high
//   imem_rdata_i     fetched instruction, sampled when imem_valid_i is high
//   imem_valid_i     fetch data valid (ignored outside FETCH)
//   instr_o          instruction presented to the decoder
//   cu_input_en_o    instr_o valid / decoder enable
//   pc_o             address of the instruction on instr_o
//   stall_i          datapath busy; the presented instruction is not committed
//   branch_i         decoder branch decision for the presented instruction
//   branch_off_i     signed halfword branch offset
//   self_instr_en_i  decoder requests injection of self_instr_i
//   self_instr_i     instruction to inject
//   end_program_i    decoder end-of-program flag
//   halted_o         sequencer halted (left only through reset)
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [15:0]       imem_rdata_i,
   input  logic              imem_valid_i,
   output logic [15:0]       instr_o,
   output logic              cu_input_en_o,
   output logic [ADDR_W-1:0] pc_o,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic [11:0]       branch_off_i,
   input  logic              self_instr_en_i,
   input  logic [15:0]       self_instr_i,
   input  logic              end_program_i,
   output logic              halted_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_INJECT = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;

   logic              presenting;
   logic              commit;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] seq_next;

   assign presenting = (state_q == ST_ISSUE) || (state_q == ST_INJECT);
   assign commit     = presenting && !stall_i;

   // Sign-extend the halfword offset to the PC width, then scale to bytes.
   // The target is relative to the address after the next instruction.
   assign off_ext   = ADDR_W'(signed'(branch_off_i));
   assign br_target = pc_q + ADDR_W'(4) + (off_ext << 1);
   assign seq_next  = pc_q + ADDR_W'(2);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
         end

         ST_FETCH: begin
            if (imem_valid_i) begin
               instr_d = imem_rdata_i;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE, ST_INJECT: begin
            // While stalled everything holds and decoder inputs are ignored.
            if (commit) begin
               if (end_program_i) begin
                  state_d = ST_HALT;
               end else if (branch_i) begin
                  pc_d    = br_target;
                  state_d = ST_FETCH;
               end else if (self_instr_en_i) begin
                  // PC stays at the parent so the following fetch is parent+2,
                  // and chained injections keep the same parent address.
                  instr_d = self_instr_i;
                  state_d = ST_INJECT;
               end else begin
                  pc_d    = seq_next;
                  state_d = ST_FETCH;
               end
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
            pc_d    = RESET_PC;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Request and decoder enable come from mutually exclusive states, so they
   // can never be high together.
   assign imem_req_o    = (state_q == ST_FETCH);
   assign imem_addr_o   = pc_q;
   assign instr_o       = instr_q;
   assign cu_input_en_o = presenting;
   assign pc_o          = pc_q;
   assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_seq
//
// Directed bench for instr_fetch_seq. A behavioural instruction memory with a
// programmable response latency answers fetch requests; expected presentations
// are queued as each step is driven and checked when the decoder enable rises.
// -----------------------------------------------------------------------------
module tb_instr_fetch_seq;

   logic        clk;
   logic        rst;
   logic        req;
   logic [15:0] addr;
   logic [15:0] rdata;
   logic        valid;
   logic [15:0] instr;
   logic        en;
   logic [15:0] pc;
   logic        stall;
   logic        branch;
   logic [11:0] off;
   logic        sie;
   logic [15:0] si;
   logic        endp;
   logic        halted;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_req = 0;
   int lat   = 1;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } pres_t;

   pres_t       sb_q[$];
   logic [15:0] mem [256];

   instr_fetch_seq #(
      .ADDR_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .imem_req_o      (req),
      .imem_addr_o     (addr),
      .imem_rdata_i    (rdata),
      .imem_valid_i    (valid),
      .instr_o         (instr),
      .cu_input_en_o   (en),
      .pc_o            (pc),
      .stall_i         (stall),
      .branch_i        (branch),
      .branch_off_i    (off),
      .self_instr_en_i (sie),
      .self_instr_i    (si),
      .end_program_i   (endp),
      .halted_o        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},    32'(req),    32'd0);
      chk({tag, "_addr"},   32'(addr),   32'h0000);
      chk({tag, "_instr"},  32'(instr),  32'h0000);
      chk({tag, "_en"},     32'(en),     32'd0);
      chk({tag, "_pc"},     32'(pc),     32'h0000);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   // Memory responder: captures a request, raises valid for one cycle after
   // 'lat' cycles, and drops any outstanding response on reset.
   initial begin
      logic        pend;
      int          cnt;
      logic [15:0] cap;
      pend  = 1'b0;
      cnt   = 0;
      cap   = '0;
      valid = 1'b0;
      rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            valid = 1'b0;
            pend  = 1'b0;
         end else if (valid) begin
            valid = 1'b0;
            pend  = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               valid = 1'b1;
               rdata = mem[cap[8:1]];
            end
         end else if (req) begin
            pend = 1'b1;
            cnt  = lat;
            cap  = addr;
         end
      end
   end

   task automatic sb_push(input logic [15:0] i, input logic [15:0] p);
      pres_t e;
      e.instr = i;
      e.pc    = p;
      sb_q.push_back(e);
   endtask

   task automatic wait_req(input logic [15:0] exp_addr);
      int n = 0;
      while (req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(req), 32'd1);
      chk("req_addr", 32'(addr), 32'(exp_addr));
      chk("req_no_en", 32'(en), 32'd0);
      t_req = cyc;
   endtask

   task automatic present(input int max_wait, input bit chk_lat);
      pres_t e;
      int    n = 0;
      while (en !== 1'b1 && n < max_wait) begin
         @(negedge clk);
         n++;
      end
      chk("pres_en", 32'(en), 32'd1);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("pres_instr", 32'(instr), 32'(e.instr));
         chk("pres_pc", 32'(pc), 32'(e.pc));
         chk("pres_no_req", 32'(req), 32'd0);
         if (chk_lat) chk("latency", 32'(cyc - t_req), 32'(lat + 1));
      end
   endtask

   task automatic commit(input logic b, input logic [11:0] o, input logic inj,
                         input logic [15:0] s, input logic e);
      branch = b;
      off    = o;
      sie    = inj;
      si     = s;
      endp   = e;
      @(negedge clk);
      branch = 1'b0;
      off    = '0;
      sie    = 1'b0;
      si     = '0;
      endp   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0]  = 16'h2005;
      mem[1]  = 16'h1840;
      mem[20] = 16'h0000;

      rst    = 1'b1;
      stall  = 1'b0;
      branch = 1'b0;
      off    = '0;
      sie    = 1'b0;
      si     = '0;
      endp   = 1'b0;
      lat    = 1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      #1 chk("idle_req", 32'(req), 32'd0);

      // T1 sequential fetch
      wait_req(16'h0000);
      sb_push(16'h2005, 16'h0000);
      present(8, 1'b1);
      commit(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0002);
      sb_push(16'h1840, 16'h0002);
      present(8, 1'b1);
      commit(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0004);
      sb_push(16'h1002, 16'h0004);
      present(8, 1'b1);

      // Forward branch 0x4+4+8 -> 0x10
      commit(1'b1, 12'h004, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0010);
      sb_push(16'h1008, 16'h0010);
      present(8, 1'b1);

      // T2 backward branch, offset -3, with inject requested too (branch wins)
      commit(1'b1, 12'hFFD, 1'b1, 16'hDEAD, 1'b0);
      wait_req(16'h000E);
      sb_push(16'h1007, 16'h000E);
      present(8, 1'b1);
      commit(1'b1, 12'h007, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0020);
      sb_push(16'h1010, 16'h0020);
      present(8, 1'b1);

      // T3 inject, then a chained inject, then parent+2
      sb_push(16'h9701, 16'h0020);
      commit(1'b0, 12'h000, 1'b1, 16'h9701, 1'b0);
      present(0, 1'b0);
      sb_push(16'hABCD, 16'h0020);
      commit(1'b0, 12'h000, 1'b1, 16'hABCD, 1'b0);
      present(0, 1'b0);
      commit(1'b0, 12'h000, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0022);
      sb_push(16'h1011, 16'h0022);
      present(8, 1'b1);

      // T4 stall with branch held for 3 cycles
      stall  = 1'b1;
      branch = 1'b1;
      off    = 12'h001;
      repeat (3) begin
         @(negedge clk);
         chk("stall_en", 32'(en), 32'd1);
         chk("stall_instr", 32'(instr), 32'h1011);
         chk("stall_pc", 32'(pc), 32'h0022);
         chk("stall_req", 32'(req), 32'd0);
      end
      lat   = 2;
      stall = 1'b0;
      commit(1'b1, 12'h001, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0028);
      sb_push(16'h0000, 16'h0028);
      present(8, 1'b1);

      // T5 end_program together with branch
      commit(1'b1, 12'h005, 1'b0, 16'h0000, 1'b1);
      repeat (8) begin
         chk("halt_flag", 32'(halted), 32'd1);
         chk("halt_en", 32'(en), 32'd0);
         chk("halt_req", 32'(req), 32'd0);
         @(negedge clk);
      end

      // T6 reset during a 3-cycle-latency fetch of 0x40
      rst = 1'b1;
      repeat (2) @(negedge clk);
      lat = 1;
      rst = 1'b0;
      wait_req(16'h0000);
      sb_push(16'h2005, 16'h0000);
      present(8, 1'b1);
      lat = 3;
      commit(1'b1, 12'h01E, 1'b0, 16'h0000, 1'b0);
      wait_req(16'h0040);
      @(negedge clk);
      chk("fetch_hold_req", 32'(req), 32'd1);
      chk("fetch_hold_addr", 32'(addr), 32'h0040);
      rst = 1'b1;
      #1 chk_reset_vals("async_rst");
      lat = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("idle_req2", 32'(req), 32'd0);
      wait_req(16'h0000);
      sb_push(16'h2005, 16'h0000);
      present(8, 1'b1);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
